booth_pp_gen: RTL and testbench

- Pipelined radix-4 Booth partial-product generator for the 16x16 signed multiplier datapath.
- Accepts operand pairs on a valid/ready handshake and produces eight 32-bit sign-extended partial products, prod[0..7].
- Each prod[i] is unshifted. The downstream carry-save tree applies the shift of 2*i bits and reduces the eight products to the 32-bit product.
- Sits directly upstream of that tree. Two register stages give full throughput with backpressure.

---
 rtl/mult_pkg.sv | 31 +++
 rtl/booth_enc_sel.sv | 24 ++
 rtl/booth_pp_gen.sv | 89 ++++++++
 tb/tb_booth_pp_gen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths, Booth digit encoding and partial-product array type for the 16x16 signed multiplier.
package mult_pkg;

  localparam int OP_W = 16;
  localparam int PP_W = 2 * OP_W;
  localparam int NPP  = OP_W / 2;

  // Magnitude select (one/two) plus sign; all-zero means digit 0.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  typedef logic [NPP-1:0][PP_W-1:0] pp_array_t;

  // Group is {b[2i+1], b[2i], b[2i-1]}; 3'b111 maps to a true zero, never "-0".
  function automatic booth_digit_t booth_encode(input logic [2:0] grp);
    booth_digit_t d;
    d = '0;
    case (grp)
      3'b001, 3'b010: d.one = 1'b1;
      3'b011:         d.two = 1'b1;
      3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end
      3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end
      default:        d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_enc_sel.sv
// One radix-4 Booth group: recodes three multiplier bits and selects 0, +-a or +-2a, fully negated.
module booth_enc_sel
  import mult_pkg::*;
(
  input  logic [2:0]      grp,
  input  logic [PP_W-1:0] a_ext,
  output logic [PP_W-1:0] pp
);

  booth_digit_t    dig;
  logic [PP_W-1:0] mag;

  always_comb begin
    dig = booth_encode(grp);
    mag = '0;
    if (dig.one) begin
      mag = a_ext;
    end else if (dig.two) begin
      mag = a_ext << 1;
    end
    pp = dig.neg ? -mag : mag;
  end

endmodule

// File: rtl/booth_pp_gen.sv
// Two-stage radix-4 Booth partial-product generator: operands -> S1 -> eight unshifted products in S2.
// Result visible one edge after the operand edge's successor; stalls hold S2, S1 fills, then in_ready drops.
module booth_pp_gen #(
  parameter int OP_W  = 16,
  parameter int PP_W  = 2 * OP_W,
  parameter int NPP   = OP_W / 2,
  parameter int TAG_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           in_a,
  input  logic [OP_W-1:0]           in_b,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NPP-1:0][PP_W-1:0]  prod,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      busy
);

  if (OP_W != mult_pkg::OP_W || PP_W != 2 * OP_W || NPP != OP_W / 2) begin : g_bad_width
    $error("booth_pp_gen supports only OP_W=16, PP_W=32, NPP=8");
  end

  logic                     s1_valid;
  logic                     s2_valid;
  logic [OP_W-1:0]          s1_a;
  logic [OP_W-1:0]          s1_b;
  logic [TAG_W-1:0]         s1_tag;
  logic                     s1_adv;
  logic                     s2_adv;
  logic                     accept;
  logic [PP_W-1:0]          a_ext;
  logic [OP_W:0]            b_ext;
  logic [NPP-1:0][PP_W-1:0] pp_d;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = rst_n && (!s1_valid || s2_adv);
  assign accept   = in_valid && in_ready;

  assign out_valid = s2_valid;
  assign busy      = s1_valid || s2_valid;

  // b[-1] = 0 is the appended LSB, so group i is b_ext[2i+2:2i].
  assign a_ext = {{(PP_W-OP_W){s1_a[OP_W-1]}}, s1_a};
  assign b_ext = {s1_b, 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_grp
    booth_enc_sel u_enc (
      .grp   (b_ext[2*i+2:2*i]),
      .a_ext (a_ext),
      .pp    (pp_d[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_tag   <= in_tag;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      prod     <= '0;
      out_tag  <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      prod     <= pp_d;
      out_tag  <= s1_tag;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_booth_pp_gen.sv
// Directed and streaming checks of booth_pp_gen against hand values and an arithmetic Booth model.
module tb_booth_pp_gen;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         in_a;
  logic [15:0]         in_b;
  logic [3:0]          in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [7:0][31:0]    prod;
  logic [3:0]          out_tag;
  logic                busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_pp_gen #(.OP_W(16), .PP_W(32), .NPP(8), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Digit straight from d = -2*b[2i+1] + b[2i] + b[2i-1], applied to signed a.
  function automatic logic [31:0] model_pp(input logic [15:0] a, input logic [15:0] b, input int i);
    logic [16:0] be;
    int sa;
    int d;
    be = {b, 1'b0};
    sa = $signed(a);
    d  = -2 * int'(be[2*i+2]) + int'(be[2*i+1]) + int'(be[2*i]);
    return 32'(sa * d);
  endfunction

  function automatic logic [31:0] shifted_sum(input logic [7:0][31:0] p);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + (p[i] << (2 * i));
    return s;
  endfunction

  function automatic logic [31:0] exact(input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    return 32'(sa * sb);
  endfunction

  task automatic directed(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] tag, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e7, input logic [31:0] esum);
    logic [7:0][31:0] exp;
    exp    = '0;
    exp[0] = e0;
    exp[1] = e1;
    exp[7] = e7;
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_early_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_tag"}, 32'(out_tag), 32'(tag));
    for (int i = 0; i < 8; i++) chk($sformatf("%s_pp%0d", nm, i), prod[i], exp[i]);
    chk({nm, "_sum"}, shifted_sum(prod), esum);
    @(posedge clk); #1;
    chk({nm, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  task automatic stream(input string nm, input int n, input bit rnd);
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [3:0]  qt[$];
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    bit acc  = 1'b0;
    bit saw_block = 1'b0;
    while (got < n && cyc < n * 20 + 50) begin
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        qa.push_back(in_a); qb.push_back(in_b); qt.push_back(in_tag);
        sent++;
      end
      in_valid = (sent < n);
      if (rnd) begin
        in_a = 16'($urandom); in_b = 16'($urandom);
        if (sent == 0) begin in_a = 16'h8000; in_b = 16'h8000; end
      end else begin
        in_a = 16'(sent * 37 - 300); in_b = 16'(sent * 1111 + 5);
      end
      in_tag    = 4'(sent);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : !(cyc >= 5 && cyc <= 8);
      #1;
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (out_valid) begin
        if (qa.size() == 0) begin
          chk({nm, "_spurious"}, 32'(out_valid), 32'd0);
        end else begin
          for (int i = 0; i < 8; i++)
            chk($sformatf("%s_pp%0d", nm, i), prod[i], model_pp(qa[0], qb[0], i));
          chk({nm, "_tag"}, 32'(out_tag), 32'(qt[0]));
          chk({nm, "_sum"}, shifted_sum(prod), exact(qa[0], qb[0]));
          if (out_ready) begin
            void'(qa.pop_front()); void'(qb.pop_front()); void'(qt.pop_front());
            got++;
          end
        end
      end
      acc = in_valid && in_ready;
    end
    in_valid = 1'b0;
    chk({nm, "_count"}, 32'(got), 32'(n));
    if (!rnd) chk({nm, "_blocked"}, 32'(saw_block), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_prod_sum", shifted_sum(prod), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    directed("a3b5",   16'd3,    16'd5,    4'd1, 32'h0000_0003, 32'h0000_0003, 32'h0, 32'd15);
    directed("am5b2",  16'hFFFB, 16'h0002, 4'd2, 32'h0000_000A, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFF6);
    directed("minmin", 16'h8000, 16'h8000, 4'd3, 32'h0,         32'h0,         32'h0001_0000, 32'h4000_0000);
    directed("a7bm1",  16'd7,    16'hFFFF, 4'd4, 32'hFFFF_FFF9, 32'h0,         32'h0, 32'hFFFF_FFF9);

    stream("strm", 20, 1'b0);

    // Fill both stages under a stall, then reset for one edge.
    out_ready = 1'b0; in_valid = 1'b1; in_a = 16'd3; in_b = 16'd5; in_tag = 4'd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstlow_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("midrst_pp%0d", i), prod[i], 32'd0);
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    stream("rand", 2000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
